// File: rtl/hack_io_pkg.sv
// Shared definitions for the Hack FPGA GPIO input path.
package hack_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  // Defaults for a 100 MHz system clock: 10 ms debounce, 1 s long press.
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1000000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 100000000;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer, polarity normalization and cycle-counting debouncer.
// Reusable for any slow mechanical contact (buttons, switches).
module sync_debounce
  import hack_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK_100MHz,
  input  logic RST_N,
  input  logic btn,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Pin level when the button is not pushed.
  localparam logic RELEASED = ACTIVE_LOW;

  logic [1:0]       sync_q;
  logic             s;
  logic [CNT_W-1:0] dcnt;

  // Bring the asynchronous pin into the clock domain, starting from released.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= {2{RELEASED}};
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign s = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Accept a level change only after it has been stable for DEBOUNCE_CYCLES.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      dcnt    <= '0;
      pressed <= 1'b0;
    end else if (s == pressed) begin
      dcnt <= '0;
    end else if (dcnt == CNT_MAX) begin
      pressed <= ~pressed;
      dcnt    <= '0;
    end else begin
      dcnt <= dcnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_input.sv
// Debounced push-button front end: clean level plus registered press,
// release and long-press events.
module button_input
  import hack_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic CLK_100MHz,
  input  logic RST_N,
  input  logic btn,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic long_held
);

  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  btn_state_t        state, state_n;
  logic [HOLD_W-1:0] hcnt, hcnt_n;
  logic              db_pressed;
  logic              rise, fall;
  logic              press_n, release_n, long_n, held_n;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_sync_debounce (
    .CLK_100MHz (CLK_100MHz),
    .RST_N      (RST_N),
    .btn        (btn),
    .pressed    (db_pressed)
  );

  // The output level is the debounced level delayed by one register so that
  // it changes on the same edge as the registered pulses.
  assign rise = db_pressed & ~pressed;
  assign fall = ~db_pressed & pressed;

  // Next state, hold counter and pulse requests; a release on the threshold
  // cycle takes priority over the long-press event.
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    held_n    = long_held;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          hcnt_n  = '0;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else if (hcnt == HOLD_MAX) begin
          state_n = LONG;
          long_n  = 1'b1;
          held_n  = 1'b1;
        end else begin
          hcnt_n = hcnt + HOLD_W'(1);
        end
      end
      LONG: begin
        if (fall) begin
          state_n   = IDLE;
          release_n = 1'b1;
          held_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        held_n  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge CLK_100MHz or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      hcnt             <= '0;
      pressed          <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      long_held        <= 1'b0;
    end else begin
      state            <= state_n;
      hcnt             <= hcnt_n;
      pressed          <= db_pressed;
      press_pulse      <= press_n;
      release_pulse    <= release_n;
      long_press_pulse <= long_n;
      long_held        <= held_n;
    end
  end

endmodule

// File: tb/tb_button_input.sv
// Self-checking bench for button_input with a sliding-window reference model.
module tb_button_input;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic pressed, press_pulse, release_pulse, long_press_pulse, long_held;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model state: pushed samples per edge and derived expectations.
  bit hist[$];
  bit m_level, m_held, e_press, e_rel, e_long;
  int m_hold;

  // Observed event counters for per-phase checks.
  int obs_press, obs_rel, obs_long;

  button_input #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .CLK_100MHz       (clk),
    .RST_N            (rst_n),
    .btn              (btn),
    .pressed          (pressed),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .long_held        (long_held)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < int'(D) + 3; i++) hist.push_back(1'b0);
    m_level = 0; m_held = 0; m_hold = 0;
    e_press = 0; e_rel = 0; e_long = 0;
  endfunction

  // The output level after edge m flips once the D pushed samples taken at
  // edges m-D-2 .. m-3 all disagree with it (2 sync edges + 1 output register).
  function automatic void model_edge(input bit p);
    bit all_diff;
    bit prev;
    int n;
    hist.push_back(p);
    n = hist.size();
    all_diff = 1;
    for (int i = 0; i < int'(D); i++)
      if (hist[n - 4 - i] == m_level) all_diff = 0;
    prev = m_level;
    if (all_diff) m_level = !m_level;
    e_press = m_level && !prev;
    e_rel   = !m_level && prev;
    e_long  = 0;
    if (e_press) begin
      m_hold = 0;
      m_held = 0;
    end else if (m_level) begin
      m_hold++;
      if (m_hold == int'(L) && !m_held) begin
        e_long = 1;
        m_held = 1;
      end
    end else begin
      m_held = 0;
    end
    if (hist.size() > 64) void'(hist.pop_front());
  endfunction

  task automatic check_outputs();
    check_eq("pressed",          pressed,          m_level);
    check_eq("press_pulse",      press_pulse,      e_press);
    check_eq("release_pulse",    release_pulse,    e_rel);
    check_eq("long_press_pulse", long_press_pulse, e_long);
    check_eq("long_held",        long_held,        m_held);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_pressed"}, pressed, 0);
    check_eq({tag, "_press"},   press_pulse, 0);
    check_eq({tag, "_release"}, release_pulse, 0);
    check_eq({tag, "_long"},    long_press_pulse, 0);
    check_eq({tag, "_held"},    long_held, 0);
  endtask

  task automatic step(input bit b);
    btn = b;
    @(posedge clk);
    model_edge(!b);
    #1;
    check_outputs();
    obs_press += int'(press_pulse);
    obs_rel   += int'(release_pulse);
    obs_long  += int'(long_press_pulse);
  endtask

  task automatic hold(input bit b, input int n);
    repeat (n) step(b);
  endtask

  task automatic clear_obs();
    obs_press = 0; obs_rel = 0; obs_long = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero(tag);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Steps btn to level b for n edges and returns the edge index of the first press pulse.
  task automatic press_edge(input bit b, input int n, output int idx);
    idx = -1;
    for (int i = 0; i < n; i++) begin
      step(b);
      if (press_pulse && idx < 0) idx = i;
    end
  endtask

  initial begin
    int idx;
    int len;
    bit lvl;

    // Reset with the pin released, then a long steady idle.
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    do_reset("reset");
    clear_obs();
    hold(1'b1, 50);
    check_eq("idle_press_cnt", obs_press, 0);
    check_eq("idle_rel_cnt",   obs_rel,   0);

    // Clean press; the release is timed so its fall lands on the long-press threshold.
    clear_obs();
    press_edge(1'b0, 20, idx);
    check_eq("clean_press_edge", idx, 2 + D);
    hold(1'b1, 20);
    check_eq("simul_release_cnt", obs_rel,  1);
    check_eq("simul_long_cnt",    obs_long, 0);

    // Bounce with runs of 1..3 cycles, then a long hold and release.
    clear_obs();
    lvl = 1'b0;
    for (int r = 0; r < 12; r++) begin
      len = int'($urandom_range(3, 1));
      hold(lvl, len);
      lvl = !lvl;
    end
    hold(1'b0, 40);
    check_eq("bounce_press_cnt", obs_press, 1);
    check_eq("long_cnt",         obs_long,  1);
    check_eq("long_held_on",     long_held, 1);
    hold(1'b1, 30);
    check_eq("long_release_cnt", obs_rel,   1);
    check_eq("long_held_off",    long_held, 0);

    // Short press.
    clear_obs();
    hold(1'b0, 10);
    hold(1'b1, 20);
    check_eq("short_press_cnt",   obs_press, 1);
    check_eq("short_release_cnt", obs_rel,   1);
    check_eq("short_long_cnt",    obs_long,  0);

    // Reset while long-held, button kept pushed through reset.
    hold(1'b0, 30);
    check_eq("pre_reset_held", long_held, 1);
    do_reset("midhold");
    clear_obs();
    press_edge(1'b0, 20, idx);
    check_eq("post_reset_press_edge", idx, 2 + D);
    hold(1'b1, 30);

    // Random runs of assorted lengths.
    for (int r = 0; r < 300; r++) begin
      lvl = 1'($urandom_range(1, 0));
      len = int'($urandom_range(12, 1));
      hold(lvl, len);
    end
    hold(1'b1, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
